// File: rtl/dnstream_loopback.sv
// -----------------------------------------------------------------------------
// dnstream_loopback
// Multi-channel AXI-Stream loopback from the Aurora 64b66b RX user interface
// to the TX user interface, clocked by the Aurora user clock.
//
// RX has no backpressure and TX does, so every channel owns a FIFO. A small
// PASS/DROP state machine per channel keeps TX framing intact when the FIFO
// overflows. If the FIFO is one beat short of full, a packet is cut short by
// forcing tlast on the last beat that fits. The rest of that packet is then
// discarded. A link-down on a channel flushes that channel's FIFO.
//
// Ports (per channel c in 0..CH_CNT-1):
//   user_clk, rst_n          clock, asynchronous active-low reset
//   channel_up[c]            link status; low = ignore RX, flush, hide TX
//   rx_tdata/tkeep/tvalid/tlast[c]  RX beats from the wrapper (no ready)
//   tx_tdata/tkeep/tvalid/tlast[c]  TX beats to the wrapper
//   tx_tready[c]             TX backpressure
//   fifo_level[c]            beats currently buffered (0..FIFO_DEPTH)
//   pkt_cnt[c]               forwarded packets, wraps at 2^32
//   drop_cnt[c]              truncated or dropped packets, saturates
//
// Build option: define DNSTREAM_LOOPBACK_STAT_EN to implement pkt_cnt and
// drop_cnt. Without it, both ports are tied to zero and the datapath is
// unchanged.
// -----------------------------------------------------------------------------
module dnstream_loopback #(
   parameter int CH_CNT     = 4,
   parameter int BYTE_W     = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                                      user_clk,
   input  logic                                      rst_n,
   input  logic [CH_CNT-1:0]                         channel_up,
   input  logic [CH_CNT-1:0][8*BYTE_W-1:0]           rx_tdata,
   input  logic [CH_CNT-1:0][BYTE_W-1:0]             rx_tkeep,
   input  logic [CH_CNT-1:0]                         rx_tvalid,
   input  logic [CH_CNT-1:0]                         rx_tlast,
   output logic [CH_CNT-1:0][8*BYTE_W-1:0]           tx_tdata,
   output logic [CH_CNT-1:0][BYTE_W-1:0]             tx_tkeep,
   output logic [CH_CNT-1:0]                         tx_tvalid,
   output logic [CH_CNT-1:0]                         tx_tlast,
   input  logic [CH_CNT-1:0]                         tx_tready,
   output logic [CH_CNT-1:0][$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CH_CNT-1:0][31:0]                   pkt_cnt,
   output logic [CH_CNT-1:0][15:0]                   drop_cnt
);

   localparam int DW = 8 * BYTE_W;
   localparam int KW = BYTE_W;
   localparam int EW = DW + KW + 1;           // {tdata, tkeep, tlast}
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] LVL_ALMOST = LW'(FIFO_DEPTH - 1);

   typedef enum logic [0:0] {
      ST_PASS = 1'b0,
      ST_DROP = 1'b1
   } rx_state_t;

   for (genvar c = 0; c < CH_CNT; c++) begin : g_ch
      logic [EW-1:0] mem_r [FIFO_DEPTH];
      logic [PW-1:0] wr_ptr_r;
      logic [PW-1:0] rd_ptr_r;
      logic [LW-1:0] level_r;
      rx_state_t     state_r;
      rx_state_t     state_nxt_s;
      logic          wr_en_s;
      logic          wr_last_s;
      logic          drop_hit_s;
      logic          tx_valid_s;
      logic          rd_en_s;
      logic [EW-1:0] head_s;

      // RX admission: decide write / truncate / discard from the registered level only
      always_comb begin
         state_nxt_s = state_r;
         wr_en_s     = 1'b0;
         wr_last_s   = rx_tlast[c];
         drop_hit_s  = 1'b0;
         if (!channel_up[c]) begin
            state_nxt_s = ST_PASS;
         end else if (rx_tvalid[c]) begin
            case (state_r)
               ST_PASS: begin
                  if (level_r < LVL_ALMOST) begin
                     wr_en_s = 1'b1;
                  end else if (level_r == LVL_ALMOST) begin
                     // Last free slot: close the packet here if it would not fit.
                     wr_en_s = 1'b1;
                     if (!rx_tlast[c]) begin
                        wr_last_s   = 1'b1;
                        drop_hit_s  = 1'b1;
                        state_nxt_s = ST_DROP;
                     end else begin
                        state_nxt_s = ST_PASS;
                     end
                  end else begin
                     // Full: nothing of this packet can be kept.
                     drop_hit_s = 1'b1;
                     if (!rx_tlast[c]) begin
                        state_nxt_s = ST_DROP;
                     end else begin
                        state_nxt_s = ST_PASS;
                     end
                  end
               end
               ST_DROP: begin
                  if (rx_tlast[c]) begin
                     state_nxt_s = ST_PASS;
                  end else begin
                     state_nxt_s = ST_DROP;
                  end
               end
               default: begin
                  state_nxt_s = ST_PASS;
               end
            endcase
         end else begin
            state_nxt_s = state_r;
         end
      end

      // Head is masked while empty so idle TX outputs read as zero
      assign tx_valid_s = (level_r != '0) && channel_up[c];
      assign rd_en_s    = tx_valid_s && tx_tready[c];
      assign head_s     = (level_r != '0) ? mem_r[rd_ptr_r] : '0;

      assign tx_tvalid[c]  = tx_valid_s;
      assign tx_tdata[c]   = head_s[EW-1 -: DW];
      assign tx_tkeep[c]   = head_s[KW:1];
      assign tx_tlast[c]   = head_s[0];
      assign fifo_level[c] = level_r;

      // Pointers, level and RX state; link-down flushes on the next edge
      always_ff @(posedge user_clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            state_r  <= ST_PASS;
         end else if (!channel_up[c]) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            state_r  <= ST_PASS;
         end else begin
            if (wr_en_s) begin
               wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (rd_en_s) begin
               rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({wr_en_s, rd_en_s})
               2'b10:   level_r <= level_r + LW'(1);
               2'b01:   level_r <= level_r - LW'(1);
               default: level_r <= level_r;
            endcase
            state_r <= state_nxt_s;
         end
      end

      // Storage array; contents need no reset because the head is masked while empty
      always_ff @(posedge user_clk) begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {rx_tdata[c], rx_tkeep[c], wr_last_s};
         end
      end

`ifdef DNSTREAM_LOOPBACK_STAT_EN
      logic [31:0] pkt_cnt_r;
      logic [15:0] drop_cnt_r;

      // Statistics survive link-down; only reset clears them
      always_ff @(posedge user_clk or negedge rst_n) begin
         if (!rst_n) begin
            pkt_cnt_r  <= 32'd0;
            drop_cnt_r <= 16'd0;
         end else begin
            if (rd_en_s && head_s[0]) begin
               pkt_cnt_r <= pkt_cnt_r + 32'd1;
            end
            if (drop_hit_s && (drop_cnt_r != 16'hFFFF)) begin
               drop_cnt_r <= drop_cnt_r + 16'd1;
            end
         end
      end

      assign pkt_cnt[c]  = pkt_cnt_r;
      assign drop_cnt[c] = drop_cnt_r;
`else
      logic stat_unused_s;
      assign stat_unused_s = drop_hit_s;
      assign pkt_cnt[c]    = 32'd0;
      assign drop_cnt[c]   = 16'd0;
`endif
   end

endmodule

// File: tb/tb_dnstream_loopback.sv
module tb_dnstream_loopback;

   localparam int CH    = 4;
   localparam int BW    = 16;
   localparam int DW    = 8 * BW;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef DNSTREAM_LOOPBACK_STAT_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   typedef logic [DW+BW:0] beat_t;   // {tdata, tkeep, tlast}

   logic                     user_clk = 1'b0;
   logic                     rst_n;
   logic [CH-1:0]            channel_up;
   logic [CH-1:0][DW-1:0]    rx_tdata;
   logic [CH-1:0][BW-1:0]    rx_tkeep;
   logic [CH-1:0]            rx_tvalid;
   logic [CH-1:0]            rx_tlast;
   logic [CH-1:0][DW-1:0]    tx_tdata;
   logic [CH-1:0][BW-1:0]    tx_tkeep;
   logic [CH-1:0]            tx_tvalid;
   logic [CH-1:0]            tx_tlast;
   logic [CH-1:0]            tx_tready;
   logic [CH-1:0][LW-1:0]    fifo_level;
   logic [CH-1:0][31:0]      pkt_cnt;
   logic [CH-1:0][15:0]      drop_cnt;

   beat_t exp_q [CH][$];
   int    exp_pkt [CH];
   int    n_tests = 0;
   int    n_fail  = 0;

   dnstream_loopback #(.CH_CNT(CH), .BYTE_W(BW), .FIFO_DEPTH(DEPTH)) dut (
      .user_clk  (user_clk),
      .rst_n     (rst_n),
      .channel_up(channel_up),
      .rx_tdata  (rx_tdata),
      .rx_tkeep  (rx_tkeep),
      .rx_tvalid (rx_tvalid),
      .rx_tlast  (rx_tlast),
      .tx_tdata  (tx_tdata),
      .tx_tkeep  (tx_tkeep),
      .tx_tvalid (tx_tvalid),
      .tx_tlast  (tx_tlast),
      .tx_tready (tx_tready),
      .fifo_level(fifo_level),
      .pkt_cnt   (pkt_cnt),
      .drop_cnt  (drop_cnt)
   );

   always #5 user_clk = ~user_clk;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected statistic value for the current build (zero when counters are absent)
   function automatic logic [159:0] es(input int v);
      return STAT ? 160'(v) : 160'(0);
   endfunction

   function automatic logic [DW-1:0] mk_data(input int c, input int t, input int i);
      return {32'(c), 32'(t), 32'(i), 32'(i * 7) ^ 32'hC0DE0000};
   endfunction

   task automatic tick();
      @(posedge user_clk);
      #1;
      rx_tvalid = '0;
      rx_tlast  = '0;
   endtask

   // Drive one RX beat on channel c; push the expected TX beat when it should be kept
   task automatic put_beat(input int c, input int t, input int i, input logic lst,
                           input logic push, input logic force_last);
      logic [DW-1:0] d;
      logic [BW-1:0] k;
      d = mk_data(c, t, i);
      k = lst ? 16'h0FFF : 16'hFFFF;
      rx_tdata[c]  = d;
      rx_tkeep[c]  = k;
      rx_tlast[c]  = lst;
      rx_tvalid[c] = 1'b1;
      if (push) exp_q[c].push_back({d, k, lst | force_last});
   endtask

   // n-beat packet on channel c; the first nkeep beats are expected on TX,
   // the last kept beat carrying tlast
   task automatic send_pkt(input int c, input int t, input int n, input int nkeep);
      for (int i = 0; i < n; i++) begin
         put_beat(c, t, i, (i == n - 1), (i < nkeep), (i == nkeep - 1));
         tick();
      end
   endtask

   task automatic wait_empty(input int c);
      int k;
      k = 0;
      while (fifo_level[c] != '0 && k < 64) begin
         @(negedge user_clk);
         k++;
      end
      chk("drain_level", 160'(fifo_level[c]), 160'(0));
      @(negedge user_clk);
      chk("drain_queue", 160'(exp_q[c].size()), 160'(0));
   endtask

   // Scoreboard: every TX handshake must match the oldest expected beat
   always @(negedge user_clk) begin
      if (rst_n === 1'b1) begin
         for (int c = 0; c < CH; c++) begin
            if (tx_tvalid[c] && tx_tready[c]) begin
               if (exp_q[c].size() == 0) begin
                  chk("unexp_beat", 160'(1), 160'(0));
               end else begin
                  beat_t e;
                  e = exp_q[c].pop_front();
                  chk("tx_beat", 160'({tx_tdata[c], tx_tkeep[c], tx_tlast[c]}), 160'(e));
                  if (e[0]) exp_pkt[c]++;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      channel_up = '0;
      rx_tdata   = '0;
      rx_tkeep   = '0;
      rx_tvalid  = '0;
      rx_tlast   = '0;
      tx_tready  = '0;
      for (int c = 0; c < CH; c++) exp_pkt[c] = 0;
      repeat (3) @(negedge user_clk);

      // Reset state
      for (int c = 0; c < CH; c++) begin
         chk("rst_tvalid", 160'(tx_tvalid[c]), 160'(0));
         chk("rst_tlast",  160'(tx_tlast[c]),  160'(0));
         chk("rst_tdata",  160'(tx_tdata[c]),  160'(0));
         chk("rst_tkeep",  160'(tx_tkeep[c]),  160'(0));
         chk("rst_level",  160'(fifo_level[c]), 160'(0));
         chk("rst_pkt",    160'(pkt_cnt[c]),   160'(0));
         chk("rst_drop",   160'(drop_cnt[c]),  160'(0));
      end
      rst_n      = 1'b1;
      channel_up = '1;
      tx_tready  = '1;
      @(negedge user_clk);

      // Pass-through on all channels with one-cycle latency
      for (int i = 0; i < 5; i++) begin
         for (int c = 0; c < CH; c++) put_beat(c, 1, i, (i == 4), 1'b1, 1'b0);
         tick();
         if (i == 0) begin
            @(negedge user_clk);
            chk("latency_tvalid", 160'(tx_tvalid), 160'(4'hF));
         end
      end
      for (int c = 0; c < CH; c++) wait_empty(c);
      for (int c = 0; c < CH; c++) begin
         chk("pass_pkt",  160'(pkt_cnt[c]),  es(1));
         chk("pass_drop", 160'(drop_cnt[c]), es(0));
      end

      // Mid-packet truncation on channel 0: 15 beats fit, the 16th closes the packet
      tx_tready[0] = 1'b0;
      send_pkt(0, 2, 20, 16);
      @(negedge user_clk);
      chk("trunc_level", 160'(fifo_level[0]), 160'(DEPTH));
      chk("trunc_drop",  160'(drop_cnt[0]),   es(1));
      send_pkt(0, 3, 3, 0);
      @(negedge user_clk);
      chk("trunc_level2", 160'(fifo_level[0]), 160'(DEPTH));
      chk("trunc_drop2",  160'(drop_cnt[0]),   es(2));
      tx_tready[0] = 1'b1;
      wait_empty(0);
      chk("trunc_pkt", 160'(pkt_cnt[0]), es(2));

      // Full at packet start on channel 1
      tx_tready[1] = 1'b0;
      for (int p = 0; p < DEPTH; p++) send_pkt(1, 10 + p, 1, 1);
      @(negedge user_clk);
      chk("full_level", 160'(fifo_level[1]), 160'(DEPTH));
      send_pkt(1, 40, 4, 0);
      @(negedge user_clk);
      chk("full_level2", 160'(fifo_level[1]), 160'(DEPTH));
      chk("full_drop",   160'(drop_cnt[1]),   es(1));
      tx_tready[1] = 1'b1;
      wait_empty(1);
      send_pkt(1, 41, 2, 2);    // intact only if the state machine is back in PASS
      wait_empty(1);
      chk("full_pkt",  160'(pkt_cnt[1]),  es(DEPTH + 2));
      chk("full_drop", 160'(drop_cnt[1]), es(1));

      // Concurrent write and read at level 8 on channel 2
      tx_tready[2] = 1'b0;
      send_pkt(2, 50, 8, 8);
      @(negedge user_clk);
      chk("conc_fill", 160'(fifo_level[2]), 160'(8));
      for (int j = 0; j < 10; j++) begin
         tx_tready[2] = 1'b1;
         put_beat(2, 51, j, (j == 9), 1'b1, 1'b0);
         tick();
         @(negedge user_clk);
         chk("conc_level", 160'(fifo_level[2]), 160'(8));
      end
      wait_empty(2);
      chk("conc_pkt", 160'(pkt_cnt[2]), es(3));

      // Link drop with 6 beats buffered on channel 3
      tx_tready[3] = 1'b0;
      send_pkt(3, 60, 6, 6);
      @(negedge user_clk);
      chk("link_fill", 160'(fifo_level[3]), 160'(6));
      @(posedge user_clk);
      #1;
      channel_up[3] = 1'b0;
      #1;
      chk("link_tvalid_comb", 160'(tx_tvalid[3]), 160'(0));
      exp_q[3].delete();
      put_beat(3, 61, 0, 1'b1, 1'b0, 1'b0);
      tick();
      @(negedge user_clk);
      chk("link_flush", 160'(fifo_level[3]), 160'(0));
      put_beat(3, 61, 1, 1'b1, 1'b0, 1'b0);
      tick();
      @(negedge user_clk);
      chk("link_ignore", 160'(fifo_level[3]), 160'(0));
      chk("link_pkt_kept",  160'(pkt_cnt[3]),  es(1));
      chk("link_drop_kept", 160'(drop_cnt[3]), es(0));
      channel_up[3] = 1'b1;
      tx_tready[3]  = 1'b1;
      send_pkt(3, 62, 2, 2);
      wait_empty(3);
      chk("link_pkt", 160'(pkt_cnt[3]), es(2));

      // Asynchronous reset in the middle of a packet on channel 0
      tx_tready[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         put_beat(0, 70, i, 1'b0, 1'b0, 1'b0);
         tick();
      end
      #2;
      rst_n = 1'b0;
      #1;
      for (int c = 0; c < CH; c++) begin
         chk("arst_tvalid", 160'(tx_tvalid[c]),  160'(0));
         chk("arst_tdata",  160'(tx_tdata[c]),   160'(0));
         chk("arst_tkeep",  160'(tx_tkeep[c]),   160'(0));
         chk("arst_tlast",  160'(tx_tlast[c]),   160'(0));
         chk("arst_level",  160'(fifo_level[c]), 160'(0));
         chk("arst_pkt",    160'(pkt_cnt[c]),    160'(0));
         chk("arst_drop",   160'(drop_cnt[c]),   160'(0));
         exp_q[c].delete();
         exp_pkt[c] = 0;
      end
      @(negedge user_clk);
      @(negedge user_clk);
      rst_n     = 1'b1;
      tx_tready = '1;
      send_pkt(0, 71, 3, 3);
      wait_empty(0);
      chk("arst_pkt_after", 160'(pkt_cnt[0]), es(1));

      for (int c = 0; c < CH; c++) chk("final_queue", 160'(exp_q[c].size()), 160'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
